// File: rtl/hls4ml_pipelined_mac.sv
// Pipelined signed multiply-accumulate lane: input regs, product regs, accumulate,
// half-up rounding and saturation to a fixed-point result. Valid-tagged, II=1, ce-stallable.
module hls4ml_pipelined_mac #(
    parameter int unsigned A_W         = 16,
    parameter int unsigned B_W         = 16,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned FRAC_SHIFT  = 8,
    parameter int unsigned MREG_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   din0,
    input  logic [B_W-1:0]   din1,
    input  logic             acc_en,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_sat
);

    localparam int unsigned P_W    = A_W + B_W;
    localparam int unsigned R_W    = ACC_W + 1;
    localparam int unsigned RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [R_W-1:0] RND =
        (FRAC_SHIFT > 0) ? (R_W'(1) << RND_SH) : '0;
    localparam logic signed [R_W-1:0] SAT_MAX =
        {{(R_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [R_W-1:0] SAT_MIN =
        {{(R_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    if (ACC_W < P_W) begin : g_chk_acc
        $error("hls4ml_pipelined_mac: ACC_W must be >= A_W+B_W");
    end
    if (MREG_STAGES < 1 || MREG_STAGES > 3) begin : g_chk_mreg
        $error("hls4ml_pipelined_mac: MREG_STAGES must be 1..3");
    end
    if (FRAC_SHIFT > ACC_W - OUT_W) begin : g_chk_shift
        $error("hls4ml_pipelined_mac: FRAC_SHIFT must be <= ACC_W-OUT_W");
    end

    // S1: operand and sideband capture
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic                  v1_q;
    logic                  e1_q;
    logic                  f1_q;
    logic                  l1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            e1_q <= 1'b0;
            f1_q <= 1'b0;
            l1_q <= 1'b0;
        end else if (ce) begin
            a_q  <= din0;
            b_q  <= din1;
            v1_q <= in_valid;
            e1_q <= acc_en;
            f1_q <= in_first;
            l1_q <= in_last;
        end
    end

    // Product stages; the first computes the full-width signed product, the rest delay it
    for (genvar i = 0; i < MREG_STAGES; i++) begin : g_mreg
        logic signed [P_W-1:0] prod_d;
        logic                  v_d;
        logic                  e_d;
        logic                  f_d;
        logic                  l_d;
        logic signed [P_W-1:0] prod_q;
        logic                  v_q;
        logic                  e_q;
        logic                  f_q;
        logic                  l_q;

        if (i == 0) begin : g_src
            assign prod_d = P_W'(a_q) * P_W'(b_q);
            assign v_d    = v1_q;
            assign e_d    = e1_q;
            assign f_d    = f1_q;
            assign l_d    = l1_q;
        end else begin : g_src
            assign prod_d = g_mreg[i-1].prod_q;
            assign v_d    = g_mreg[i-1].v_q;
            assign e_d    = g_mreg[i-1].e_q;
            assign f_d    = g_mreg[i-1].f_q;
            assign l_d    = g_mreg[i-1].l_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                prod_q <= '0;
                v_q    <= 1'b0;
                e_q    <= 1'b0;
                f_q    <= 1'b0;
                l_q    <= 1'b0;
            end else if (ce) begin
                prod_q <= prod_d;
                v_q    <= v_d;
                e_q    <= e_d;
                f_q    <= f_d;
                l_q    <= l_d;
            end
        end
    end

    logic signed [P_W-1:0] pm;
    logic                  pm_v;
    logic                  pm_e;
    logic                  pm_f;
    logic                  pm_l;

    assign pm   = g_mreg[MREG_STAGES-1].prod_q;
    assign pm_v = g_mreg[MREG_STAGES-1].v_q;
    assign pm_e = g_mreg[MREG_STAGES-1].e_q;
    assign pm_f = g_mreg[MREG_STAGES-1].f_q;
    assign pm_l = g_mreg[MREG_STAGES-1].l_q;

    // Accumulate stage: multiply-only beats bypass the running sum without disturbing it
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] val_q;
    logic signed [ACC_W-1:0] val_d;
    logic                    av_q;
    logic                    emit_d;

    always_comb begin
        acc_d  = acc_q;
        val_d  = val_q;
        emit_d = 1'b0;
        prod_x = ACC_W'(pm);
        if (pm_v) begin
            if (!pm_e) begin
                val_d  = prod_x;
                emit_d = 1'b1;
            end else begin
                acc_d  = (pm_f ? '0 : acc_q) + prod_x;
                val_d  = acc_d;
                emit_d = pm_l;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            val_q <= '0;
            av_q  <= 1'b0;
        end else if (ce) begin
            acc_q <= acc_d;
            val_q <= val_d;
            av_q  <= emit_d;
        end
    end

    // Round stage, one bit wider so the half-up add cannot wrap
    logic signed [R_W-1:0] rnd_sum;
    logic signed [R_W-1:0] r_d;
    logic signed [R_W-1:0] r_q;
    logic                  rv_q;

    assign rnd_sum = R_W'(val_q) + RND;
    assign r_d     = rnd_sum >>> FRAC_SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q  <= '0;
            rv_q <= 1'b0;
        end else if (ce) begin
            if (av_q) begin
                r_q <= r_d;
            end
            rv_q <= av_q;
        end
    end

    // Saturate into output registers; dout/dout_sat hold between results
    logic [OUT_W-1:0] dout_d;
    logic             sat_d;

    always_comb begin
        dout_d = r_q[OUT_W-1:0];
        sat_d  = 1'b0;
        if (r_q > SAT_MAX) begin
            dout_d = SAT_MAX[OUT_W-1:0];
            sat_d  = 1'b1;
        end else if (r_q < SAT_MIN) begin
            dout_d = SAT_MIN[OUT_W-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout      <= '0;
            dout_sat  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (rv_q) begin
                dout     <= dout_d;
                dout_sat <= sat_d;
            end
            out_valid <= rv_q;
        end
    end

endmodule

// File: tb/tb_hls4ml_pipelined_mac.sv
// Directed scoreboard bench for hls4ml_pipelined_mac at default parameters.
module tb_hls4ml_pipelined_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [15:0] din1;
    logic        acc_en;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic [15:0] dout;
    logic        dout_sat;

    always #5 clk = ~clk;

    hls4ml_pipelined_mac dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .din0      (din0),
        .din1      (din1),
        .acc_en    (acc_en),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .dout      (dout),
        .dout_sat  (dout_sat)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          ce_at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   ce_cnt   = 0;
    logic ce_s     = 1'b0;
    logic rst_s    = 1'b1;

    // ce-enabled edge counter gives latency in pipeline cycles
    always @(posedge clk) begin
        ce_s  <= ce;
        rst_s <= reset;
        if (ce && !reset) ce_cnt <= ce_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // A new result exists only after an enabled, non-reset edge
    always @(negedge clk) begin
        if (!rst_s && ce_s && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("dout", 32'(dout), 32'(mon_e.d));
                check("dout_sat", 32'(dout_sat), 32'(mon_e.s));
                check("latency", 32'(ce_cnt), 32'(mon_e.ce_at));
            end
        end
    end

    function automatic logic [16:0] rs(input longint v);
        longint r;
        r = (v + 64'sd128) >>> 8;
        if (r > 64'sd32767) return {1'b1, 16'h7FFF};
        if (r < -64'sd32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    task automatic beat(input int a, input int b, input logic en, input logic f, input logic l,
                        input logic push, input logic [15:0] ed, input logic es);
        exp_t e;
        in_valid = 1'b1;
        din0     = a[15:0];
        din1     = b[15:0];
        acc_en   = en;
        in_first = f;
        in_last  = l;
        @(posedge clk);
        #1;
        if (push) begin
            e.d     = ed;
            e.s     = es;
            e.ce_at = ce_cnt + 5;
            sb.push_back(e);
        end
    endtask

    task automatic mbeat(input int a, input int b);
        logic [16:0] m;
        m = rs(longint'(a) * longint'(b));
        beat(a, b, 1'b0, 1'b0, 1'b0, 1'b1, m[15:0], m[16]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'(0));
        idle(2);
    endtask

    initial begin
        reset    = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        din0     = '0;
        din1     = '0;
        acc_en   = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_dout", 32'(dout), 32'(0));
        check("reset_sat", 32'(dout_sat), 32'(0));

        // multiply mode, single beat then an 8-beat back-to-back stream
        beat(768, 512, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0600, 1'b0);
        drain();
        for (int i = 0; i < 8; i++) mbeat(i * 1000 - 3500, 523 - i * 97);
        drain();

        // rounding half-up with arithmetic shift
        beat(3, 43, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
        beat(-3, 43, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        beat(-1, 128, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        drain();

        // saturation both directions, then outputs hold while idle
        beat(32767, 32767, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        beat(-32768, 32767, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1);
        drain();
        check("hold_out_valid", 32'(out_valid), 32'(0));
        check("hold_dout", 32'(dout), 32'(16'h8000));
        check("hold_sat", 32'(dout_sat), 32'(1));

        // accumulate 4 terms, then a single-term sum
        beat(256, 256, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beat(256, 256, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        beat(256, 256, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        beat(256, 256, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0400, 1'b0);
        beat(512, 256, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0);
        drain();

        // multiply-only beat interleaved inside an open sum, with a bubble
        beat(256, 256, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beat(768, 512, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0600, 1'b0);
        idle(1);
        beat(256, 256, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b0);
        drain();

        // stall three cycles after beat 2 of a 6-beat stream
        for (int i = 0; i < 3; i++) mbeat(1200 + i * 311, -700 + i * 150);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        for (int i = 3; i < 6; i++) mbeat(1200 + i * 311, -700 + i * 150);
        drain();

        // reset with an open sum discards it
        beat(256, 256, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        beat(256, 256, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'(0));
        check("rst_mid_dout", 32'(dout), 32'(0));
        check("rst_mid_sat", 32'(dout_sat), 32'(0));
        beat(256, 1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0);
        drain();
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
